// File: rtl/mem_write_router.sv
// mem_write_router: 1-to-N_CH write router with a one-entry output register per transaction.
//   in_valid/in_ready/in_we/in_data/in_addr/in_sel : upstream write transaction and handshake
//   ch_we/ch_data/ch_addr/ch_ready                 : per-bank write ports, packed k*W +: W
//   sel_err                                         : sticky flag for out-of-range bank selects
//   wr_cnt                                          : per-bank saturating accepted-write counters, 8 bits each
module mem_write_router #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int N_CH     = 3,
    parameter int SEL_W    = 2,
    parameter int ADDR_SEL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_we,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [N_CH-1:0]          ch_we,
    output logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH-1:0]          ch_ready,
    output logic                     sel_err,
    output logic [N_CH*8-1:0]        wr_cnt
);
    localparam int NB = 2**SEL_W;
    localparam logic [SEL_W:0] NCH_V = (SEL_W+1)'(N_CH);

    logic              pend_q, pend_d, we_q, we_d, sel_err_q, sel_err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_in;
    logic [SEL_W-1:0]  bank_q, bank_d, bank;
    logic [NB-1:0]     rdy_ext;
    logic              accept, load;

    // ch_ready is widened to the full select range so bank_q can index it safely
    always_comb begin
        bank    = ADDR_SEL != 0 ? in_addr[ADDR_W-1 -: SEL_W] : in_sel;
        addr_in = in_addr;
        if (ADDR_SEL != 0) addr_in[ADDR_W-1 -: SEL_W] = '0;
        rdy_ext = '0;
        rdy_ext[N_CH-1:0] = ch_ready;
        in_ready  = !pend_q || rdy_ext[bank_q];
        accept    = in_valid && in_ready;
        load      = accept && ({1'b0, bank} < NCH_V);
        pend_d    = load || (pend_q && !rdy_ext[bank_q]);
        we_d      = load ? in_we   : we_q;
        data_d    = load ? in_data : data_q;
        addr_d    = load ? addr_in : addr_q;
        bank_d    = load ? bank    : bank_q;
        sel_err_d = sel_err_q || (accept && !load);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            we_q      <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            bank_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            we_q      <= we_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            bank_q    <= bank_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic       hit;
        logic [7:0] cnt_q, cnt_d;
        assign hit   = pend_q && (bank_q == SEL_W'(k));
        assign ch_we[k] = hit && we_q;
        assign ch_data[k*DATA_W +: DATA_W] = hit ? data_q : '0;
        assign ch_addr[k*ADDR_W +: ADDR_W] = hit ? addr_q : '0;
        assign cnt_d = (ch_we[k] && ch_ready[k] && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        assign wr_cnt[k*8 +: 8] = cnt_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_write_router.sv
// tb_mem_write_router: directed vector table plus hand sequences for stall, streaming, saturation, reset and address-decoded banks.
module tb_mem_write_router;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_we = 1'b0;
    logic [15:0] in_data = '0, in_addr = '0;
    logic [1:0]  in_sel = '0;
    logic [2:0]  ch_ready = 3'b111;
    logic        in_ready, sel_err, a_ready, a_err;
    logic [2:0]  ch_we, a_we;
    logic [47:0] ch_data, ch_addr, a_data, a_addr;
    logic [23:0] wr_cnt, a_cnt;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    mem_write_router #(.ADDR_SEL(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
        .in_data(in_data), .in_addr(in_addr), .in_sel(in_sel), .ch_we(ch_we), .ch_data(ch_data),
        .ch_addr(ch_addr), .ch_ready(ch_ready), .sel_err(sel_err), .wr_cnt(wr_cnt)
    );

    mem_write_router #(.ADDR_SEL(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .in_we(in_we),
        .in_data(in_data), .in_addr(in_addr), .in_sel(in_sel), .ch_we(a_we), .ch_data(a_data),
        .ch_addr(a_addr), .ch_ready(ch_ready), .sel_err(a_err), .wr_cnt(a_cnt)
    );

    typedef struct {
        logic        v, we;
        logic [1:0]  sel;
        logic [15:0] addr, data;
        logic [2:0]  rdy;
        logic        e_rdy;
        logic [2:0]  e_we;
        logic [47:0] e_data, e_addr;
        logic        e_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                         input logic [15:0] addr, input logic [15:0] data, input logic [2:0] rdy);
        in_valid = v; in_we = we; in_sel = sel; in_addr = addr; in_data = data; ch_ready = rdy;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 3'b111, 1'b1, 3'b000, 48'h0, 48'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'd1, 16'h0040, 16'hBEEF, 3'b111, 1'b1, 3'b000, 48'h0, 48'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 3'b111, 1'b1, 3'b010, 48'h0000_BEEF_0000, 48'h0000_0040_0000, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 2'd2, 16'h0010, 16'h1111, 3'b111, 1'b1, 3'b000, 48'h0, 48'h0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 2'd0, 16'h0020, 16'h2222, 3'b011, 1'b0, 3'b100, 48'h1111_0000_0000, 48'h0010_0000_0000, 1'b0};
        tbl[5]  = tbl[4];
        tbl[6]  = tbl[4];
        tbl[7]  = '{1'b1, 1'b1, 2'd0, 16'h0020, 16'h2222, 3'b111, 1'b1, 3'b100, 48'h1111_0000_0000, 48'h0010_0000_0000, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 3'b001, 1'b1, 3'b001, 48'h0000_0000_2222, 48'h0000_0000_0020, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 2'd1, 16'h0030, 16'h3333, 3'b111, 1'b1, 3'b000, 48'h0, 48'h0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 3'b101, 1'b0, 3'b000, 48'h0000_3333_0000, 48'h0000_0030_0000, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 3'b111, 1'b1, 3'b000, 48'h0000_3333_0000, 48'h0000_0030_0000, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 2'd3, 16'h0044, 16'h4444, 3'b111, 1'b1, 3'b000, 48'h0, 48'h0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 3'b111, 1'b1, 3'b000, 48'h0, 48'h0, 1'b1};

        repeat (2) @(negedge clk);
        #1;
        chk("reset ch_we", 64'(ch_we), 64'(0));
        chk("reset ch_data", 64'(ch_data), 64'(0));
        chk("reset ch_addr", 64'(ch_addr), 64'(0));
        chk("reset in_ready", 64'(in_ready), 64'(1));
        chk("reset sel_err", 64'(sel_err), 64'(0));
        chk("reset wr_cnt", 64'(wr_cnt), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].we, tbl[i].sel, tbl[i].addr, tbl[i].data, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d ch_we", i), 64'(ch_we), 64'(tbl[i].e_we));
            chk($sformatf("vec%0d ch_data", i), 64'(ch_data), 64'(tbl[i].e_data));
            chk($sformatf("vec%0d ch_addr", i), 64'(ch_addr), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d sel_err", i), 64'(sel_err), 64'(tbl[i].e_err));
        end
        @(negedge clk);
        #1;
        chk("table wr_cnt", 64'(wr_cnt), 64'(24'h010101));

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, (i % 2 != 0) ? 2'd2 : 2'd0, 16'(16'h0100 + i), 16'(16'h5000 + i), 3'b111);
            #1;
            chk($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'(1));
            if (i > 0)
                chk($sformatf("stream%0d ch_we", i), 64'(ch_we), ((i - 1) % 2 != 0) ? 64'(3'b100) : 64'(3'b001));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 3'b111);
        #1;
        chk("stream last ch_we", 64'(ch_we), 64'(3'b100));
        chk("stream last ch_data", 64'(ch_data), 64'(48'h5005_0000_0000));
        chk("sel_err sticky", 64'(sel_err), 64'(1));
        @(negedge clk);
        #1;
        chk("stream wr_cnt", 64'(wr_cnt), 64'(24'h040104));

        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 2'd0, 16'(i), 16'(i), 3'b111);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 3'b111);
        @(negedge clk);
        #1;
        chk("saturate wr_cnt", 64'(wr_cnt), 64'(24'h0401FF));

        @(negedge clk);
        drive(1'b1, 1'b1, 2'd1, 16'h0077, 16'h7777, 3'b101);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 3'b101);
        #1;
        chk("stall ch_we", 64'(ch_we), 64'(3'b010));
        chk("stall in_ready", 64'(in_ready), 64'(0));
        #1;
        rst = 1'b1;
        #1;
        chk("async rst ch_we", 64'(ch_we), 64'(0));
        chk("async rst ch_data", 64'(ch_data), 64'(0));
        chk("async rst ch_addr", 64'(ch_addr), 64'(0));
        chk("async rst wr_cnt", 64'(wr_cnt), 64'(0));
        chk("async rst sel_err", 64'(sel_err), 64'(0));
        chk("async rst in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        drive(1'b1, 1'b1, 2'd0, 16'h8123, 16'hABCD, 3'b111);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 16'h0, 16'h0, 3'b111);
        #1;
        chk("addrsel ch_we", 64'(a_we), 64'(3'b100));
        chk("addrsel ch_addr", 64'(a_addr), 64'(48'h0123_0000_0000));
        chk("addrsel ch_data", 64'(a_data), 64'(48'hABCD_0000_0000));
        chk("explicit sel ch_we", 64'(ch_we), 64'(3'b001));
        chk("explicit sel ch_addr", 64'(ch_addr), 64'(48'h0000_0000_8123));
        @(negedge clk);
        #1;
        chk("addrsel wr_cnt", 64'(a_cnt), 64'(24'h010000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_write_router.md
# mem_write_router

Parametrised 1-to-N write-port router for the CNN memory subsystem. It accepts one write transaction per cycle (write enable, data, address) on a valid/ready handshake and steers it to one of N_CH memory-bank write ports. Each output port has its own ready, and the block holds the transaction in a one-entry output register until the selected bank accepts it. The bank is taken from an explicit select input or decoded from the upper address bits, and out-of-range selects are flagged and dropped.

## Interface
Parameters:
- DATA_W, 16, data width
- ADDR_W, 16, address width
- N_CH, 3, number of output channels (2..16)
- SEL_W, 2, select width, must satisfy 2**SEL_W >= N_CH
- ADDR_SEL, 0, 0 = bank from in_sel; 1 = bank from in_addr[ADDR_W-1 -: SEL_W]

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  transaction present
- in_ready  out  1  router can accept this cycle
- in_we  in  1  write enable of transaction
- in_data  in  DATA_W  write data
- in_addr  in  ADDR_W  write address
- in_sel  in  SEL_W  bank select (ignored when ADDR_SEL=1)
- ch_we  out  N_CH  per-channel write strobe, one-hot or zero
- ch_data  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- ch_addr  out  N_CH*ADDR_W  channel k occupies bits [k*ADDR_W +: ADDR_W]
- ch_ready  in  N_CH  bank k accepts strobe this cycle
- sel_err  out  1  sticky, set on out-of-range select
- wr_cnt  out  N_CH*8  per-channel accepted-write counters, saturating at 255

## Operation
- Input accept: accept = in_valid && in_ready.
- Bank decode: bank = in_sel, or the addr upper bits when ADDR_SEL=1.
- Address stripping (ADDR_SEL=1 only): the stored address has its top SEL_W bits forced to 0.
- Output register contents: pend, we_q, data_q, addr_q, bank_q.
- Strobe: ch_we[k] = pend && we_q && (bank_q == k).
- Idle channels: every channel k != bank_q, or all channels when !pend, drives ch_data = 0 and ch_addr = 0.
- Selected channel: drives data_q and addr_q.
- Completion: the pending entry completes when pend && ch_ready[bank_q].
- Zero-enable entries: an entry with we_q=0 completes on ch_ready regardless, with no strobe. It occupies one slot and is not counted.
- in_ready = !pend || ch_ready[bank_q]. This gives full throughput when the bank is ready (load and retire in the same cycle).
- Out-of-range select (bank >= N_CH): the transaction is accepted (in_ready per rule above) but not loaded. pend is cleared if it retires the same cycle. sel_err is set to 1 and stays set until rst.
- Counters: wr_cnt[k] increments on each ch_we[k] && ch_ready[k] and saturates at 255.
- Held outputs: outputs are registered, and pend/data/addr/bank hold stable while a bank stalls.

## Timing
- Reset (async assert, sync-safe release): pend=0, we_q=0, data_q=0, addr_q=0, bank_q=0, sel_err=0, all wr_cnt=0.
- Outputs during reset: ch_we=0, all ch_data/ch_addr=0, in_ready=1.
- Latency: a transaction accepted in cycle n appears on its channel in cycle n+1.
- Minimum residency: one cycle; residency extends while ch_ready[bank_q]=0.
- Back-to-back: consecutive accepts to the same or different banks sustain one per cycle while the target ch_ready=1.
- Stall: if ch_ready[bank_q]=0, in_ready=0 and the input must hold. The router ignores in_* changes while in_ready=0.
- Simultaneous retire + accept: the new entry overwrites the output register at the same edge the old one is counted.
- ch_ready on non-selected channels has no effect.
- Reset mid-stall: the pending entry is discarded with no strobe, and counters clear.
- sel_err is set at the edge of the erroneous accept and is visible from the next cycle.

## Test plan
- Reset, then one write: in_sel=1, addr=0x0040, data=0xBEEF, ch_ready=3'b111. Required response: cycle+1 gives ch_we=3'b010, ch1 data/addr = 0xBEEF/0x0040, ch0/ch2 data and addr 0; wr_cnt[1]=1.
- Stall: target ch2, ch_ready[2]=0 for 3 cycles. Required response: in_ready=0 and ch2 outputs held for 3 cycles; a single strobe completes on release; wr_cnt[2]=1.
- Streaming: 6 back-to-back writes alternating sel 0/2, all ready. Required response: one strobe per cycle with no bubbles; wr_cnt[0]=3, wr_cnt[2]=3.
- Out-of-range: in_sel=3 with N_CH=3. Required response: no strobe; sel_err=1 next cycle and remains 1 through later valid writes.
- ADDR_SEL=1 with SEL_W=2: in_addr=0x8123. Required response: ch2 strobes with addr=0x0123.
- Saturation and reset: 260 writes to ch0 give wr_cnt[0]=255. Asserting rst mid-stall then clears all outputs asynchronously with no strobe emitted.
